arm_execute_pipe: RTL and testbench



---
 rtl/arm_execute_pipe_pkg.sv | 46 ++++
 rtl/arm_execute_pipe_val2_generator.sv | 40 ++++
 rtl/arm_execute_pipe.sv | 121 ++++++++++++
 tb/tb_arm_execute_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_execute_pipe_pkg.sv
// Shared encodings for the ARM-subset execute slice: ALU commands, shift types,
// status-register bit positions and the ID/EX register layout.
package arm_execute_pipe_pkg;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic        imm;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
    } id_ex_t;

endpackage

// File: rtl/arm_execute_pipe_val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
    import arm_execute_pipe_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    logic [4:0]  rot;
    logic [4:0]  amt;
    logic [63:0] imm_rot;
    logic [63:0] rm_rot;

    assign rot = {shift_operand[11:8], 1'b0};
    assign amt = shift_operand[11:7];

    // Rotations fall out of shifting a doubled word and keeping the low half.
    assign imm_rot = {24'd0, shift_operand[7:0], 24'd0, shift_operand[7:0]} >> rot;
    assign rm_rot  = {val_rm, val_rm} >> amt;

    always_comb begin
        val2 = val_rm;
        if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = imm_rot[31:0];
        end else begin
            case (shift_operand[6:5])
                SH_LSL:  val2 = val_rm << amt;
                SH_LSR:  val2 = val_rm >> amt;
                SH_ASR:  val2 = $signed(val_rm) >>> amt;
                default: val2 = rm_rot[31:0];
            endcase
        end
    end

endmodule

// File: rtl/arm_execute_pipe.sv
// Execute slice: ID/EX register, Val2/ALU/branch adder, NZCV register, EX/MEM register.
module arm_execute_pipe
    import arm_execute_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    output logic [3:0]  exe_dest,
    output logic        exe_wb_en,
    output logic        branch_taken,
    output logic [31:0] br_addr,
    output logic [3:0]  sr,
    output logic        mem_wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic [3:0]  mem_dest
);

    id_ex_t      id_ex;
    logic [31:0] val2;
    logic [31:0] res;
    logic [32:0] wide;
    logic        c_next;
    logic        v_next;
    logic        cin;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            id_ex <= '0;
        end else begin
            id_ex <= '{wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
                       pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in, dest_in};
        end
    end

    assign exe_dest     = id_ex.dest;
    assign exe_wb_en    = id_ex.wb_en;
    assign branch_taken = id_ex.b;
    assign br_addr      = id_ex.pc + {{6{id_ex.signed_imm_24[23]}}, id_ex.signed_imm_24, 2'b00};

    val2_generator u_val2 (
        .mem_en        (id_ex.mem_r_en | id_ex.mem_w_en),
        .imm           (id_ex.imm),
        .shift_operand (id_ex.shift_operand),
        .val_rm        (id_ex.val_rm),
        .val2          (val2)
    );

    always_comb begin
        res    = '0;
        wide   = '0;
        cin    = 1'b0;
        c_next = sr[SR_C];
        v_next = sr[SR_V];
        case (id_ex.exe_cmd)
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD, EXE_ADC: begin
                cin    = (id_ex.exe_cmd == EXE_ADC) ? sr[SR_C] : 1'b0;
                wide   = {1'b0, id_ex.val_rn} + {1'b0, val2} + {32'd0, cin};
                res    = wide[31:0];
                c_next = wide[32];
                v_next = (id_ex.val_rn[31] == val2[31]) && (res[31] != id_ex.val_rn[31]);
            end
            EXE_SUB, EXE_SBC: begin
                // SBC borrows one extra when C is clear; carry out is NOT borrow.
                cin    = (id_ex.exe_cmd == EXE_SBC) ? ~sr[SR_C] : 1'b0;
                wide   = {1'b0, id_ex.val_rn} - {1'b0, val2} - {32'd0, cin};
                res    = wide[31:0];
                c_next = ~wide[32];
                v_next = (id_ex.val_rn[31] != val2[31]) && (res[31] != id_ex.val_rn[31]);
            end
            EXE_AND: res = id_ex.val_rn & val2;
            EXE_ORR: res = id_ex.val_rn | val2;
            EXE_EOR: res = id_ex.val_rn ^ val2;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (id_ex.s) begin
            sr <= {res[31], (res == 32'd0), c_next, v_next};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_en  <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            alu_result <= '0;
            st_val     <= '0;
            mem_dest   <= '0;
        end else begin
            mem_wb_en  <= id_ex.wb_en;
            mem_r_en   <= id_ex.mem_r_en;
            mem_w_en   <= id_ex.mem_w_en;
            alu_result <= res;
            st_val     <= id_ex.val_rm;
            mem_dest   <= id_ex.dest;
        end
    end

endmodule

// File: tb/tb_arm_execute_pipe.sv
// Scoreboard bench for arm_execute_pipe: directed cases from the plan, then random traffic.
module tb_arm_execute_pipe;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic [3:0]  exe_dest;
    logic        exe_wb_en, branch_taken;
    logic [31:0] br_addr;
    logic [3:0]  sr;
    logic        mem_wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_result, st_val;
    logic [3:0]  mem_dest;

    arm_execute_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .branch_taken(branch_taken), .br_addr(br_addr), .sr(sr),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_result(alu_result), .st_val(st_val), .mem_dest(mem_dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb, mr, mw, b, s, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] so;
        logic [23:0] off;
        logic [3:0]  dest;
    } ins_t;

    typedef struct {
        int          cap;
        logic        b;
        logic [31:0] br;
        logic [3:0]  edest;
        logic        ewb;
        logic        mwb, mr, mw;
        logic [31:0] res, st;
        logic [3:0]  mdest, sr;
    } exp_t;

    exp_t exq[$];
    exp_t memq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [3:0] m_sr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        int k = n % 32;
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    function automatic logic [31:0] model_val2(input ins_t i);
        int amt = int'(i.so[11:7]);
        logic signed [31:0] srm = i.rm;
        if (i.mr || i.mw) return {20'd0, i.so};
        if (i.imm) return ror({24'd0, i.so[7:0]}, 2 * int'(i.so[11:8]));
        case (i.so[6:5])
            2'd0:    return i.rm << amt;
            2'd1:    return i.rm >> amt;
            2'd2:    return srm >>> amt;
            default: return ror(i.rm, amt);
        endcase
    endfunction

    // Executes one instruction against the model flags; returns result and next flags.
    task automatic model_alu(input ins_t i, output logic [31:0] res, inout logic [3:0] f);
        logic [31:0] v2 = model_val2(i);
        longint ua = longint'(i.rn);
        longint ub = longint'(v2);
        longint sa = longint'($signed(i.rn));
        longint sb = longint'($signed(v2));
        longint u, s, k;
        logic c = f[1], v = f[0];
        res = 32'd0;
        case (i.cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                k = (i.cmd == 4'd3) ? longint'(f[1]) : 0;
                u = ua + ub + k; s = sa + sb + k;
                res = u[31:0]; c = (u > 64'sd4294967295);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                k = (i.cmd == 4'd5) ? longint'(!f[1]) : 0;
                u = ua - ub - k; s = sa - sb - k;
                res = u[31:0]; c = (u >= 0);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: res = i.rn & v2;
            4'd7: res = i.rn | v2;
            4'd8: res = i.rn ^ v2;
            default: res = 32'd0;
        endcase
        if (i.s) f = {res[31], res == 32'd0, c, v};
    endtask

    // Drives one instruction at the current negedge and records its expectations.
    task automatic issue(input ins_t i, input logic fl);
        ins_t e = fl ? '0 : i;
        exp_t x;
        int off;
        flush = fl;
        wb_en_in = i.wb; mem_r_en_in = i.mr; mem_w_en_in = i.mw; b_in = i.b;
        s_in = i.s; imm_in = i.imm; exe_cmd_in = i.cmd; pc_in = i.pc;
        val_rn_in = i.rn; val_rm_in = i.rm; shift_operand_in = i.so;
        signed_imm_24_in = i.off; dest_in = i.dest;
        off = $signed(e.off);
        x.cap = cyc + 1;
        x.b = e.b; x.br = e.pc + 32'(off * 4); x.edest = e.dest; x.ewb = e.wb;
        x.mwb = e.wb; x.mr = e.mr; x.mw = e.mw; x.st = e.rm; x.mdest = e.dest;
        model_alu(e, x.res, m_sr);
        x.sr = m_sr;
        exq.push_back(x);
        memq.push_back(x);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (exq.size() > 0 && exq[0].cap <= cyc) begin
            if (exq[0].cap == cyc) begin
                chk("branch_taken", 32'(branch_taken), 32'(exq[0].b));
                chk("br_addr", br_addr, exq[0].br);
                chk("exe_dest", 32'(exe_dest), 32'(exq[0].edest));
                chk("exe_wb_en", 32'(exe_wb_en), 32'(exq[0].ewb));
            end else begin
                chk("exe_missed", 32'(cyc), 32'(exq[0].cap));
            end
            void'(exq.pop_front());
        end
        while (memq.size() > 0 && memq[0].cap + 1 <= cyc) begin
            if (memq[0].cap + 1 == cyc) begin
                chk("alu_result", alu_result, memq[0].res);
                chk("st_val", st_val, memq[0].st);
                chk("mem_dest", 32'(mem_dest), 32'(memq[0].mdest));
                chk("mem_ctrl", {29'd0, mem_wb_en, mem_r_en, mem_w_en},
                    {29'd0, memq[0].mwb, memq[0].mr, memq[0].mw});
                chk("sr", 32'(sr), 32'(memq[0].sr));
            end else begin
                chk("mem_missed", 32'(cyc), 32'(memq[0].cap + 1));
            end
            void'(memq.pop_front());
        end
    end

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        ins_t i;
        int   guard;
        m_sr = 4'd0;
        rst = 1'b1; flush = 1'b1;
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; imm_in = 1;
        exe_cmd_in = 4'd2; pc_in = 32'h1234; val_rn_in = 32'd9; val_rm_in = 32'd9;
        shift_operand_in = 12'h0FF; signed_imm_24_in = 24'h000010; dest_in = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_exe", {exe_dest, exe_wb_en, branch_taken}, 32'd0);
        chk("rst_br_addr", br_addr, 32'd0);
        chk("rst_sr", 32'(sr), 32'd0);
        chk("rst_mem", {mem_dest, mem_wb_en, mem_r_en, mem_w_en}, 32'd0);
        chk("rst_data", alu_result | st_val, 32'd0);
        rst = 1'b0;

        i = '0; i.cmd = 4'd2; i.imm = 1; i.s = 1; i.rn = 5; i.so = 12'h003; i.wb = 1; i.dest = 1;
        issue(i, 0);
        i = '0; i.cmd = 4'd4; i.s = 1; i.rn = 3; i.rm = 3;
        issue(i, 0);
        i = '0; i.cmd = 4'd3; i.imm = 1; i.rn = 1; i.so = 12'h001;
        issue(i, 0);
        i = '0; i.cmd = 4'd2; i.imm = 1; i.s = 1; i.rn = 32'h7FFF_FFFF; i.so = 12'h001;
        issue(i, 0);
        i.s = 0; i.rn = 32'h0000_0010;
        issue(i, 0);
        i = '0; i.cmd = 4'd2; i.imm = 1; i.s = 1; i.rn = 32'hFFFF_FFFF; i.so = 12'h001;
        issue(i, 0);
        i = '0; i.cmd = 4'd1; i.imm = 1; i.so = 12'h1FF;
        issue(i, 0);
        i = '0; i.cmd = 4'd1; i.so = 12'h240; i.rm = 32'h8000_0000;
        issue(i, 0);
        i = '0; i.b = 1; i.pc = 32'h100; i.off = 24'hFFFFFE;
        issue(i, 0);
        i = '0; i.cmd = 4'd2; i.mr = 1; i.wb = 1; i.rn = 32'h400; i.so = 12'h008; i.rm = 7; i.dest = 3;
        issue(i, 0);
        issue(i, 1);

        for (int n = 0; n < 400; n++) begin
            i.wb = 1'($urandom); i.b = ($urandom_range(0, 3) == 0); i.s = 1'($urandom);
            i.imm = 1'($urandom);
            i.mr = ($urandom_range(0, 5) == 0); i.mw = !i.mr && ($urandom_range(0, 5) == 0);
            i.cmd = 4'($urandom_range(0, 15)); i.pc = $urandom; i.rn = pick32(); i.rm = pick32();
            i.so = 12'($urandom); i.off = 24'($urandom); i.dest = 4'($urandom);
            issue(i, $urandom_range(0, 9) == 0);
        end

        guard = 0;
        while ((exq.size() > 0 || memq.size() > 0) && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (exq.size() > 0 || memq.size() > 0)
            chk("drain_timeout", 32'(exq.size() + memq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
